mem_port_arbiter: RTL

Shares one single-port unified word memory between the instruction-fetch port and the load/store port of the RV32I core. It arbitrates between the two ports and sequences each access through a fixed-latency memory. It generates byte enables and lane-replicated write data for SB/SH/SW, and extracts and sign- or zero-extends load data for LB/LBU/LH/LHU/LW. It sits between the PC/fetch logic, the execute stage and the memory macro.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one fixed-latency single-port word memory,
// with RV32I byte-lane steering for stores and extraction/extension for loads.
module mem_port_arbiter #(
   parameter int ADDR_W  = 12,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [2:0]        ls_funct3,
   input  logic [31:0]       ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [31:0]       ls_rdata,
   output logic              ls_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

   state_t      state, state_nx;
   logic [2:0]  cnt;
   logic        owner;      // 1 = load/store owns the access in flight
   logic        last_ls;
   logic        err_r, we_r;
   logic [2:0]  f3_r;
   logic [1:0]  lane_r;
   logic [31:0] rdata_r, ext;
   logic        ls_bad, ls_ok, gnt_ls, gnt_if, idle;
   logic [31:0] shifted;
   logic [15:0] half;

   logic unused;
   assign unused = ^{if_addr[1:0], if_addr[31:ADDR_W+2], ls_addr[31:ADDR_W+2]};

   always_comb begin
      ls_bad = 1'b1;
      case (ls_funct3)
         3'b000:         ls_bad = 1'b0;
         3'b001:         ls_bad = ls_addr[0];
         3'b010:         ls_bad = (ls_addr[1:0] != 2'b00);
         3'b100, 3'b101: ls_bad = ls_we | (ls_funct3[0] & ls_addr[0]);
         default:        ls_bad = 1'b1;
      endcase
   end

   // Reset gates grants so every output is 0 while reset is held.
   assign idle   = (state == IDLE) && !reset;
   assign gnt_ls = idle && ls_req && (!if_req || !last_ls);
   assign gnt_if = idle && if_req && !gnt_ls;
   assign ls_ok  = gnt_ls && !ls_bad;

   always_comb begin
      mem_en    = gnt_if | ls_ok;
      mem_we    = ls_ok & ls_we;
      mem_be    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = 32'd0;
      if (gnt_if) begin
         mem_be   = 4'b1111;
         mem_addr = if_addr[ADDR_W+1:2];
      end else if (ls_ok) begin
         mem_be   = 4'b1111;
         mem_addr = ls_addr[ADDR_W+1:2];
         if (ls_we) begin
            case (ls_funct3[1:0])
               2'b00: begin
                  mem_be    = 4'b0001 << ls_addr[1:0];
                  mem_wdata = {4{ls_wdata[7:0]}};
               end
               2'b01: begin
                  mem_be    = ls_addr[1] ? 4'b1100 : 4'b0011;
                  mem_wdata = {2{ls_wdata[15:0]}};
               end
               default: mem_wdata = ls_wdata;
            endcase
         end
      end
   end

   assign shifted = mem_rdata >> {lane_r, 3'b000};
   assign half    = lane_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      ext = mem_rdata;
      if (owner) begin
         case (f3_r)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'd0, shifted[7:0]};
            3'b001:  ext = {{16{half[15]}}, half};
            3'b101:  ext = {16'd0, half};
            default: ext = mem_rdata;
         endcase
         if (we_r) ext = 32'd0;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (gnt_ls && ls_bad) state_nx = RESP;
               else if (gnt_ls || gnt_if) state_nx = WAIT;
         WAIT: if (cnt == LAST) state_nx = RESP;
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         owner   <= 1'b0;
         last_ls <= 1'b0;
         err_r   <= 1'b0;
         we_r    <= 1'b0;
         f3_r    <= 3'd0;
         lane_r  <= 2'd0;
         rdata_r <= 32'd0;
      end else begin
         state <= state_nx;
         if (gnt_ls || gnt_if) begin
            owner   <= gnt_ls;
            last_ls <= gnt_ls;
            err_r   <= gnt_ls & ls_bad;
            we_r    <= gnt_ls & ls_we;
            f3_r    <= ls_funct3;
            lane_r  <= ls_addr[1:0];
            rdata_r <= 32'd0;
            cnt     <= 3'd0;
         end else if (state == WAIT) begin
            if (cnt == LAST) rdata_r <= ext;
            else             cnt     <= cnt + 3'd1;
         end
      end
   end

   assign if_gnt    = gnt_if;
   assign ls_gnt    = gnt_ls;
   assign busy      = (state != IDLE);
   assign if_rvalid = (state == RESP) && !owner;
   assign ls_rvalid = (state == RESP) && owner;
   assign if_rdata  = if_rvalid ? rdata_r : 32'd0;
   assign ls_rdata  = ls_rvalid ? rdata_r : 32'd0;
   assign ls_err    = ls_rvalid & err_r;
endmodule
